// File: rtl/h2c_pkt_replayer_pkg.sv
`default_nettype none
// ============================================================================
// Module : h2c_gen_pkg
// Brief  : Shared state encoding and beat record for the H2C packet replayer.
// Rev    : 1.0
// ============================================================================
package h2c_gen_pkg;

  localparam int BEAT_DATA_W = 512;
  localparam int BEAT_MTY_W  = 6;

  localparam logic [BEAT_MTY_W-1:0] MTY_FULL = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic [BEAT_MTY_W-1:0]  mty;
    logic                   last;
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/h2c_pkt_replayer_if.sv
`default_nettype none
// ============================================================================
// Module : h2c_pkt_replayer_if
// Brief  : AXI-Stream bundle feeding the QDMA H2C input of the shell.
// Rev    : 1.0
// ============================================================================
interface h2c_pkt_replayer_if
  import h2c_gen_pkg::*;
#(
  parameter int DATA_W = BEAT_DATA_W,
  parameter int MTY_W  = BEAT_MTY_W
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [MTY_W-1:0]  tuser_mty;
  logic [31:0]       tuser_mdata;

  modport master (output tdata, tvalid, tlast, tuser_mty, tuser_mdata, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser_mty, tuser_mdata, output tready);
endinterface
`default_nettype wire

// File: rtl/h2c_pkt_replayer_beat_ram.sv
`default_nettype none
// ============================================================================
// Module : h2c_beat_ram
// Brief  : Simple dual-port beat store; one write port, one registered read.
// Rev    : 1.0
// ============================================================================
module h2c_beat_ram
  import h2c_gen_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  beat_t             wr_beat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output beat_t             rd_beat
);

  beat_t mem_q [DEPTH];
  beat_t rd_beat_q, rd_beat_d;

  // Storage is deliberately not reset so a replay survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_beat;
    end
  end

  always_comb begin
    rd_beat_d = rd_beat_q;
    if (rd_en) begin
      rd_beat_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_beat_q <= '{data: '0, mty: MTY_FULL, last: 1'b0};
    end else begin
      rd_beat_q <= rd_beat_d;
    end
  end

  assign rd_beat = rd_beat_q;

endmodule
`default_nettype wire

// File: rtl/h2c_pkt_replayer.sv
`default_nettype none
// ============================================================================
// Module : h2c_pkt_replayer
// Brief  : Replays preloaded 512-bit beats onto the QDMA H2C AXI-Stream port.
// Rev    : 1.0
// ============================================================================
module h2c_pkt_replayer
  import h2c_gen_pkg::*;
#(
  parameter int DATA_W = BEAT_DATA_W,
  parameter int MTY_W  = BEAT_MTY_W,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int GAP_W  = 16
) (
  input  logic                axis_aclk,
  input  logic                axis_rstn,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [MTY_W-1:0]    wr_mty,
  input  logic                wr_last,
  input  logic                start,
  input  logic [ADDR_W:0]     num_beats,
  input  logic [GAP_W-1:0]    gap_cycles,
  input  logic [31:0]         mdata,
  h2c_pkt_replayer_if.master  m_axis,
  output logic                busy,
  output logic                done,
  output logic [15:0]         pkt_cnt,
  output logic                err_trunc
);

  localparam logic [ADDR_W:0] MAX_BEATS = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d, cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [31:0]       mdata_q, mdata_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              done_q, done_d, err_q, err_d;
  logic [ADDR_W:0]   eff_cnt;
  logic              hs, is_final, out_last, rd_en, ram_we;
  beat_t             wr_beat, rd_beat;

  assign eff_cnt  = (num_beats > MAX_BEATS) ? MAX_BEATS : num_beats;
  assign hs       = (state_q == ST_SEND) && m_axis.tready;
  assign is_final = (ptr_q == cnt_q - 1'b1);
  // A run that ends mid-packet still closes the packet on the wire.
  assign out_last = rd_beat.last | ((state_q == ST_SEND) && is_final);
  assign ram_we   = wr_en && (state_q == ST_IDLE);
  assign wr_beat  = '{data: wr_data, mty: wr_mty, last: wr_last};

  h2c_beat_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (axis_aclk),
    .rst_n   (axis_rstn),
    .wr_en   (ram_we),
    .wr_addr (wr_addr),
    .wr_beat (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (ptr_q[ADDR_W-1:0]),
    .rd_beat (rd_beat)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    mdata_d   = mdata_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mdata_d = mdata;
          gap_d   = gap_cycles;
          if (eff_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = eff_cnt;
            ptr_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          ptr_d = ptr_q + 1'b1;
          if (out_last) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end
          if (is_final) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (!rd_beat.last) begin
              err_d = 1'b1;
            end
          end else if (rd_beat.last && (gap_q != '0)) begin
            gap_cnt_d = gap_q;
            state_d   = ST_GAP;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      mdata_q   <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      mdata_q   <= mdata_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign m_axis.tdata       = DATA_W'(rd_beat.data);
  assign m_axis.tuser_mty   = MTY_W'(rd_beat.mty);
  assign m_axis.tlast       = out_last;
  assign m_axis.tvalid      = (state_q == ST_SEND);
  assign m_axis.tuser_mdata = mdata_q;
  assign busy               = (state_q != ST_IDLE);
  assign done               = done_q;
  assign pkt_cnt            = pkt_cnt_q;
  assign err_trunc          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_h2c_pkt_replayer.sv
`default_nettype none
// ============================================================================
// Module : tb_h2c_pkt_replayer
// Brief  : Directed self-checking bench for the H2C packet replayer.
// Rev    : 1.0
// ============================================================================
module tb_h2c_pkt_replayer;
  import h2c_gen_pkg::*;

  localparam int ADDR_W = 6;

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic              wr_en, wr_last, start;
  logic [ADDR_W-1:0] wr_addr;
  logic [511:0]      wr_data;
  logic [5:0]        wr_mty;
  logic [ADDR_W:0]   num_beats;
  logic [15:0]       gap_cycles;
  logic [31:0]       mdata;
  logic              busy, done, err_trunc;
  logic [15:0]       pkt_cnt;

  h2c_pkt_replayer_if #(.DATA_W(512), .MTY_W(6)) m_axis ();

  h2c_pkt_replayer #(.DATA_W(512), .MTY_W(6), .DEPTH(64), .ADDR_W(ADDR_W), .GAP_W(16)) dut (
    .axis_aclk  (clk),
    .axis_rstn  (rstn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mty     (wr_mty),
    .wr_last    (wr_last),
    .start      (start),
    .num_beats  (num_beats),
    .gap_cycles (gap_cycles),
    .mdata      (mdata),
    .m_axis     (m_axis),
    .busy       (busy),
    .done       (done),
    .pkt_cnt    (pkt_cnt),
    .err_trunc  (err_trunc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int base  = 0;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int i);
    pat = {16{32'hC0DE_0000 | 32'(i)}};
  endfunction

  logic [511:0] q_data[$];
  logic         q_last[$];
  logic [5:0]   q_mty[$];
  int           q_cyc[$];
  int           done_cnt = 0;
  int           done_cyc = 0;
  logic         busy_at_done = 1'b1;
  logic         p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
  logic [511:0] p_data = '0;
  logic [5:0]   p_mty = '0;

  // Observe the bus away from the active edge.
  always @(negedge clk) begin
    if (rstn && p_vld && !p_rdy) begin
      chk("stall_valid", int'(m_axis.tvalid), 1);
      chkw("stall_data", m_axis.tdata, p_data);
      chk("stall_last", int'(m_axis.tlast), int'(p_last));
      chk("stall_mty", int'(m_axis.tuser_mty), int'(p_mty));
    end
    p_vld  = rstn && m_axis.tvalid;
    p_rdy  = m_axis.tready;
    p_data = m_axis.tdata;
    p_last = m_axis.tlast;
    p_mty  = m_axis.tuser_mty;
    if (m_axis.tvalid && m_axis.tready) begin
      q_data.push_back(m_axis.tdata);
      q_last.push_back(m_axis.tlast);
      q_mty.push_back(m_axis.tuser_mty);
      q_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  task automatic clrq();
    q_data.delete();
    q_last.delete();
    q_mty.delete();
    q_cyc.delete();
  endtask

  task automatic write_beat(input int a, input logic [511:0] d, input int mty, input logic last);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    wr_mty  = 6'(mty);
    wr_last = last;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int nb, input int gap, input logic [31:0] md);
    start      = 1'b1;
    num_beats  = 7'(nb);
    gap_cycles = 16'(gap);
    mdata      = md;
    base       = done_cnt;
    @(posedge clk); #1;
    t0         = cyc;
    start      = 1'b0;
    num_beats  = 7'd0;
    gap_cycles = 16'd5;
    mdata      = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == base; k++) begin
      @(posedge clk); #1;
      m_axis.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("done_seen", int'(done_cnt > base), 1);
    m_axis.tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0; wr_mty = '0; wr_last = 1'b0;
    num_beats = '0; gap_cycles = '0; mdata = '0; m_axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", int'(m_axis.tvalid), 0);
    chk("rst_tlast", int'(m_axis.tlast), 0);
    chkw("rst_tdata", m_axis.tdata, '0);
    chk("rst_mty", int'(m_axis.tuser_mty), 0);
    chk("rst_mdata", int'(m_axis.tuser_mdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pkt_cnt", int'(pkt_cnt), 0);
    chk("rst_err", int'(err_trunc), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single two-beat packet, ready held high.
    write_beat(0, pat(0), 0, 1'b0);
    write_beat(1, pat(1), 44, 1'b1);
    clrq();
    start_run(2, 0, 32'h1234_5678);
    wait_done(50);
    chk("t1_nbeats", q_data.size(), 2);
    chkw("t1_data0", q_data[0], pat(0));
    chkw("t1_data1", q_data[1], pat(1));
    chk("t1_last0", int'(q_last[0]), 0);
    chk("t1_last1", int'(q_last[1]), 1);
    chk("t1_mty0", int'(q_mty[0]), 0);
    chk("t1_mty1", int'(q_mty[1]), 44);
    chk("t1_latency", q_cyc[0], t0 + 1);
    chk("t1_spacing", q_cyc[1] - q_cyc[0], 2);
    chk("t1_done_cyc", done_cyc, t0 + 4);
    chk("t1_busy_at_done", int'(busy_at_done), 0);
    chk("t1_done_once", done_cnt - base, 1);
    chk("t1_pkt_cnt", int'(pkt_cnt), 1);
    chk("t1_mdata", int'(m_axis.tuser_mdata), int'(32'h1234_5678));
    chk("t1_err", int'(err_trunc), 0);

    // Four packets with a 30-cycle gap; a write and a start while busy are dropped.
    for (int i = 0; i < 8; i++) write_beat(i, pat(i), (i % 2 == 1) ? 10 + i : 0, (i % 2 == 1));
    clrq();
    start_run(8, 30, 32'h0000_00AA);
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = ~pat(5); wr_mty = 6'd63; wr_last = 1'b0;
    start = 1'b1; num_beats = 7'd1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    wait_done(400);
    chk("t2_nbeats", q_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chkw("t2_data", q_data[i], pat(i));
      chk("t2_last", int'(q_last[i]), i % 2);
      chk("t2_mty", int'(q_mty[i]), (i % 2 == 1) ? 10 + i : 0);
    end
    for (int i = 1; i < 8; i++) chk("t2_spacing", q_cyc[i] - q_cyc[i-1], (i % 2 == 0) ? 32 : 2);
    chk("t2_done_once", done_cnt - base, 1);
    chk("t2_pkt_cnt", int'(pkt_cnt), 5);
    chk("t2_mdata", int'(m_axis.tuser_mdata), 32'hAA);

    // Same eight beats under random backpressure.
    clrq();
    rand_rdy = 1'b1;
    start_run(8, 3, 32'h0000_00BB);
    wait_done(600);
    rand_rdy = 1'b0;
    chk("t3_nbeats", q_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chkw("t3_data", q_data[i], pat(i));
      chk("t3_last", int'(q_last[i]), i % 2);
    end
    chk("t3_pkt_cnt", int'(pkt_cnt), 9);
    chk("t3_err", int'(err_trunc), 0);

    // Truncated run; beat 2 is rewritten in the same cycle as start.
    clrq();
    wr_en = 1'b1; wr_addr = 6'd2; wr_data = pat(102); wr_mty = 6'd7; wr_last = 1'b0;
    start_run(3, 0, 32'h0000_00CC);
    wr_en = 1'b0;
    wait_done(50);
    chk("t4_nbeats", q_data.size(), 3);
    chk("t4_last0", int'(q_last[0]), 0);
    chkw("t4_data2", q_data[2], pat(102));
    chk("t4_last2_forced", int'(q_last[2]), 1);
    chk("t4_mty2", int'(q_mty[2]), 7);
    chk("t4_err", int'(err_trunc), 1);
    chk("t4_pkt_cnt", int'(pkt_cnt), 11);

    // Zero-length run.
    clrq();
    start_run(0, 0, 32'h0000_00DD);
    wait_done(20);
    chk("t5_nbeats", q_data.size(), 0);
    chk("t5_done_cyc", done_cyc, t0);
    chk("t5_busy_at_done", int'(busy_at_done), 0);
    chk("t5_done_once", done_cnt - base, 1);
    chk("t5_pkt_cnt", int'(pkt_cnt), 11);

    // Oversized count clamps to the full memory.
    for (int i = 0; i < 64; i++) write_beat(i, pat(i), (i % 4 == 3) ? 5 : 0, (i % 4 == 3));
    clrq();
    start_run(100, 0, 32'h0000_00EE);
    wait_done(400);
    chk("t6_nbeats", q_data.size(), 64);
    for (int i = 0; i < 64; i++) chkw("t6_data", q_data[i], pat(i));
    chk("t6_last63", int'(q_last[63]), 1);
    chk("t6_pkt_cnt", int'(pkt_cnt), 27);

    // Reset in the middle of SEND, then replay from address 0.
    clrq();
    start_run(8, 0, 32'h0000_00FF);
    for (int k = 0; k < 10 && !m_axis.tvalid; k++) @(negedge clk);
    chk("t7_in_send", int'(m_axis.tvalid), 1);
    #1 rstn = 1'b0;
    #1;
    chk("t7_rst_tvalid", int'(m_axis.tvalid), 0);
    chk("t7_rst_busy", int'(busy), 0);
    chk("t7_rst_pkt_cnt", int'(pkt_cnt), 0);
    chk("t7_rst_err", int'(err_trunc), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    clrq();
    start_run(3, 0, 32'h0000_0011);
    wait_done(50);
    chk("t7_nbeats", q_data.size(), 3);
    for (int i = 0; i < 3; i++) chkw("t7_data", q_data[i], pat(i));
    chk("t7_last2_forced", int'(q_last[2]), 1);
    chk("t7_err", int'(err_trunc), 1);
    chk("t7_pkt_cnt", int'(pkt_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/h2c_pkt_replayer.md
# h2c_pkt_replayer

Synthesizable packet source that replays a preloaded sequence of 512-bit beats onto the QDMA H2C AXI-Stream input of `open_nic_shell`. It carries config packets and data packets, with tlast, mty and a programmable inter-packet gap. It sits directly upstream of the shell's `s_axis_qdma_h2c_sim_*` port and replaces hand-written beat sequences in on-chip self-test and simulation.

## Interface
- `DATA_W`, 512: tdata width.
- `MTY_W`, 6: empty-byte count width.
- `DEPTH`, 64: beat memory entries; power of two.
- `ADDR_W`, $clog2(DEPTH): beat address width.
- `GAP_W`, 16: gap counter width.

Ports (one clock; reset is asynchronous and active-low):
- `axis_aclk` in 1: clock.
- `axis_rstn` in 1: asynchronous active-low reset.
- `wr_en` in 1: write one beat into memory.
- `wr_addr` in ADDR_W: beat address.
- `wr_data` in DATA_W: beat payload.
- `wr_mty` in MTY_W: empty bytes of the beat.
- `wr_last` in 1: beat ends a packet.
- `start` in 1: begin replay; sampled only in IDLE.
- `num_beats` in ADDR_W+1: beats to replay from address 0; values above DEPTH are clamped to DEPTH.
- `gap_cycles` in GAP_W: idle cycles inserted after each tlast handshake.
- `mdata` in 32: driven unchanged on `m_axis_tuser_mdata`.
- `m_axis_tdata` out DATA_W: output payload.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: output beat ends a packet.
- `m_axis_tuser_mty` out MTY_W: empty bytes of the output beat.
- `m_axis_tuser_mdata` out 32: copy of `mdata`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when replay completes.
- `pkt_cnt` out 16: packets sent since reset; wraps at 0xFFFF→0.
- `err_trunc` out 1: sticky; final beat forced to tlast.

## Operation
- FSM states: IDLE, FETCH, SEND, GAP.
- **IDLE**: `start`=1 with effective count 0 pulses `done` next cycle and stays in IDLE. `start`=1 with count ≥1 latches the count, sets read pointer = 0, and moves to FETCH.
- **FETCH**: issues a synchronous read at the pointer, then moves to SEND. Memory data lands in the output register on entry to SEND.
- **SEND**: `m_axis_tvalid`=1. On handshake (`tvalid` && `tready`), the pointer increments and:
  - If it was the final beat: go to IDLE and pulse `done`.
  - Else if the beat had tlast and `gap_cycles`>0: go to GAP, loading the counter with `gap_cycles`.
  - Else: go to FETCH.
- **GAP**: decrements the counter each cycle. Moves to FETCH in the cycle the counter reads 1.
- Final beat with stored last=0: `m_axis_tlast` is forced to 1 and `err_trunc` is set.
- `pkt_cnt` increments on every tlast handshake, including a forced one.
- `wr_en` while `busy`=1 is ignored; memory is unchanged.
- `start` while `busy`=1 is ignored.
- `num_beats`, `gap_cycles` and `mdata` are sampled at start and held for the whole run.
- Reset (asynchronous, any state) returns the FSM to IDLE. It does not clear memory contents.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tuser_mty`=0, `m_axis_tuser_mdata`=0, `busy`=0, `done`=0, `pkt_cnt`=0, `err_trunc`=0.
- `start` sampled at edge t → FETCH during t+1 → `tvalid` high during t+2.
- Throughput is one beat per two cycles when `tready` is held high. The dead cycle is FETCH.
- A gap of G inserts exactly G extra idle cycles between the tlast handshake and the next FETCH.
- While `tvalid`=1 and `tready`=0: tdata, tlast and mty are held stable and `tvalid` stays high. `tvalid` never drops without a handshake.
- `done` is asserted in the cycle after the final handshake, which is the same cycle `busy` returns to 0.
- A `wr_en` in the same cycle as an accepted `start` is applied; the write lands before the first FETCH read.

## Structure
- Package `h2c_gen_pkg` holds:
  - The state enum.
  - The `beat_t` struct {data, mty, last}.
  - A `MTY_FULL` constant = 0.
- Sub-module `h2c_beat_ram`: simple dual-port memory of `beat_t`, one write port and one registered read port.

## Test plan
- Load 2 beats (beat 0: last=0, mty=0; beat 1: last=1, mty=44), `num_beats`=2, gap=0, `tready`=1 → 2 beats out; tlast only on beat 1; mty 0 then 44; `pkt_cnt`=1; `done` 1 cycle after beat 1.
- Four 2-beat packets, gap=30 → exactly 30 idle cycles after each tlast handshake; `pkt_cnt`=4; `done` once.
- `tready` toggled pseudo-randomly → data/tlast/mty stable under stall; all 8 beats delivered in order, none duplicated.
- `num_beats`=3 where beat 2 has last=0 → beat 2 emitted with tlast=1; `err_trunc`=1; `pkt_cnt` increments.
- `num_beats`=0 → no tvalid; `done` pulses the cycle after start. `num_beats`=100 with DEPTH=64 → 64 beats out.
- `axis_rstn` asserted mid-SEND → `tvalid`=0 immediately; `busy`=0; a new start replays from address 0 with memory intact.
